// File: rtl/dequeue_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// dequeue_scheduler_pkg
// Shared definitions for the dequeue scheduler and its round-robin arbiter:
// default queue count, counter width, FSM state encoding and the CPU read
// address map (0..NUM_Q-1 -> per-queue packet counters, NUM_Q -> abort counter).
// -----------------------------------------------------------------------------
package dequeue_scheduler_pkg;

  localparam int DEF_NUM_Q         = 5;
  localparam int DEF_CNT_W         = 32;
  localparam int DEF_MAX_PKT_BEATS = 64;

  // CPU address of the watchdog abort counter (one past the last queue)
  localparam int ABORT_ADDR = DEF_NUM_Q;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_WAIT   = 2'd2,
    S_STREAM = 2'd3
  } deq_state_t;

endpackage

// File: rtl/dequeue_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter: grants the first eligible index at
// or after ptr, wrapping at N.
//   eligible  in  N      request vector
//   ptr       in  PTR_W  index with highest priority this cycle
//   grant     out N      one-hot grant (zero when nothing is eligible)
//   valid     out 1      some index was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  always_comb begin
    int               idx;
    logic [PTR_W-1:0] sel;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = PTR_W'(idx);
      if (!valid && eligible[sel]) begin
        grant[sel] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dequeue_scheduler.sv
// -----------------------------------------------------------------------------
// dequeue_scheduler
// Round-robin dequeue controller for NUM_Q PIFO/packet-buffer queue pairs
// (index NUM_Q-1 is the CPU queue). Picks an eligible queue (non-empty and
// egress ready), pops its PIFO for one cycle, waits for the popped descriptor,
// then holds that queue's buffer read enable until tlast. A watchdog aborts a
// packet after MAX_PKT_BEATS beats without tlast.
// Ports:
//   axis_aclk, axis_resetn       clock, asynchronous active-low reset
//   s_axis_pifo_empty[NUM_Q]     per-queue PIFO empty
//   s_axis_port_ready[NUM_Q]     per-queue egress ready
//   m_axis_ctl_pifo_out_en       one-hot single-cycle PIFO pop
//   s_axis_pifo_out_valid        popped descriptor valid (sampled in WAIT only)
//   m_axis_ctl_buffer_rd_en      one-hot buffer read enable (STREAM only)
//   s_axis_buf_tvalid/tlast      buffer beat handshake
//   m_axis_busy                  FSM not in IDLE
//   s_axi_addr/req_valid         CPU counter read request
//   m_axi_data/resp_valid        CPU read response, one cycle after request
// Build option: DEQ_STRICT_CPU_PRIO_EN -- the CPU queue always wins when it is
// eligible and its packets do not advance the round-robin pointer.
// -----------------------------------------------------------------------------
module dequeue_scheduler
  import dequeue_scheduler_pkg::*;
#(
  parameter int NUM_Q         = DEF_NUM_Q,
  parameter int MAX_PKT_BEATS = DEF_MAX_PKT_BEATS,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             axis_aclk,
  input  logic             axis_resetn,
  input  logic [NUM_Q-1:0] s_axis_pifo_empty,
  input  logic [NUM_Q-1:0] s_axis_port_ready,
  output logic [NUM_Q-1:0] m_axis_ctl_pifo_out_en,
  input  logic             s_axis_pifo_out_valid,
  output logic [NUM_Q-1:0] m_axis_ctl_buffer_rd_en,
  input  logic             s_axis_buf_tvalid,
  input  logic             s_axis_buf_tlast,
  output logic             m_axis_busy,
  input  logic [3:0]       s_axi_addr,
  input  logic             s_axi_req_valid,
  output logic [31:0]      m_axi_data,
  output logic             m_axi_resp_valid
);

  localparam int PTR_W  = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam int BEAT_W = $clog2(MAX_PKT_BEATS + 1);

  deq_state_t        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [NUM_Q-1:0]  grant_oh;
  logic [BEAT_W-1:0] beat_cnt;
  logic [CNT_W-1:0]  pkt_cnt [NUM_Q];
  logic [CNT_W-1:0]  abort_cnt;

  logic [NUM_Q-1:0]  eligible;
  logic [NUM_Q-1:0]  arb_grant;
  logic              arb_valid;
  logic [NUM_Q-1:0]  sel_grant;
  logic [PTR_W-1:0]  sel_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic              beat;

  logic              resp_vld_p1;
  logic [31:0]       resp_data_p1;
  logic [31:0]       rd_data_p0;

  function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
    return 32'(v);
  endfunction

  assign eligible = ~s_axis_pifo_empty & s_axis_port_ready;

  rr_arbiter #(.N(NUM_Q), .PTR_W(PTR_W)) u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (arb_grant),
    .valid    (arb_valid)
  );

  always_comb begin
    sel_grant = arb_grant;
    next_ptr  = (grant_idx == PTR_W'(NUM_Q - 1)) ? '0 : grant_idx + 1'b1;
`ifdef DEQ_STRICT_CPU_PRIO_EN
    if (eligible[NUM_Q-1]) sel_grant = NUM_Q'(1) << (NUM_Q - 1);
    if (grant_idx == PTR_W'(NUM_Q - 1)) next_ptr = rr_ptr;
`endif
    sel_idx = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (sel_grant[i]) sel_idx = PTR_W'(i);
    end
  end

  // Read enable follows the frozen grant's egress ready combinationally, so a
  // ready drop stalls the stream without consuming a beat.
  assign m_axis_ctl_buffer_rd_en = (state == S_STREAM) ? (grant_oh & s_axis_port_ready) : '0;
  assign beat        = (|m_axis_ctl_buffer_rd_en) & s_axis_buf_tvalid;
  assign m_axis_busy = (state != S_IDLE);

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state                  <= S_IDLE;
      rr_ptr                 <= '0;
      grant_idx              <= '0;
      grant_oh               <= '0;
      beat_cnt               <= '0;
      abort_cnt              <= '0;
      m_axis_ctl_pifo_out_en <= '0;
      for (int i = 0; i < NUM_Q; i++) pkt_cnt[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_valid) begin
            grant_oh               <= sel_grant;
            grant_idx              <= sel_idx;
            m_axis_ctl_pifo_out_en <= sel_grant;
            state                  <= S_POP;
          end
        end
        S_POP: begin
          m_axis_ctl_pifo_out_en <= '0;
          state                  <= S_WAIT;
        end
        S_WAIT: begin
          if (s_axis_pifo_out_valid) begin
            beat_cnt <= '0;
            state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (s_axis_buf_tlast) begin
              pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + 1'b1;
              rr_ptr             <= next_ptr;
              state              <= S_IDLE;
            end else if (beat_cnt == BEAT_W'(MAX_PKT_BEATS - 1)) begin
              // watchdog: this beat is the limit and carried no tlast
              abort_cnt <= abort_cnt + 1'b1;
              rr_ptr    <= next_ptr;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: counter select from current (pre-increment) counter values
  always_comb begin
    rd_data_p0 = '0;
    if (int'(s_axi_addr) < NUM_Q) begin
      rd_data_p0 = zext_cnt(pkt_cnt[s_axi_addr[PTR_W-1:0]]);
    end else if (int'(s_axi_addr) == NUM_Q) begin
      rd_data_p0 = zext_cnt(abort_cnt);
    end
  end

  // Stage p1: registered response
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      resp_vld_p1  <= 1'b0;
      resp_data_p1 <= '0;
    end else begin
      resp_vld_p1 <= s_axi_req_valid;
      if (s_axi_req_valid) resp_data_p1 <= rd_data_p0;
    end
  end

  assign m_axi_resp_valid = resp_vld_p1;
  assign m_axi_data       = resp_data_p1;

endmodule

// File: tb/tb_dequeue_scheduler.sv
module tb_dequeue_scheduler;

  logic        axis_aclk = 1'b0;
  logic        axis_resetn;
  logic [4:0]  s_axis_pifo_empty;
  logic [4:0]  s_axis_port_ready;
  logic [4:0]  m_axis_ctl_pifo_out_en;
  logic        s_axis_pifo_out_valid;
  logic [4:0]  m_axis_ctl_buffer_rd_en;
  logic        s_axis_buf_tvalid;
  logic        s_axis_buf_tlast;
  logic        m_axis_busy;
  logic [3:0]  s_axi_addr;
  logic        s_axi_req_valid;
  logic [31:0] m_axi_data;
  logic        m_axi_resp_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  dequeue_scheduler dut (
    .axis_aclk               (axis_aclk),
    .axis_resetn             (axis_resetn),
    .s_axis_pifo_empty       (s_axis_pifo_empty),
    .s_axis_port_ready       (s_axis_port_ready),
    .m_axis_ctl_pifo_out_en  (m_axis_ctl_pifo_out_en),
    .s_axis_pifo_out_valid   (s_axis_pifo_out_valid),
    .m_axis_ctl_buffer_rd_en (m_axis_ctl_buffer_rd_en),
    .s_axis_buf_tvalid       (s_axis_buf_tvalid),
    .s_axis_buf_tlast        (s_axis_buf_tlast),
    .m_axis_busy             (m_axis_busy),
    .s_axi_addr              (s_axi_addr),
    .s_axi_req_valid         (s_axi_req_valid),
    .m_axi_data              (m_axi_data),
    .m_axi_resp_valid        (m_axi_resp_valid)
  );

  always #5 axis_aclk = ~axis_aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic clear_inputs();
    s_axis_pifo_empty     = 5'b11111;
    s_axis_port_ready     = 5'b11111;
    s_axis_pifo_out_valid = 1'b0;
    s_axis_buf_tvalid     = 1'b0;
    s_axis_buf_tlast      = 1'b0;
    s_axi_addr            = 4'd0;
    s_axi_req_valid       = 1'b0;
  endtask

  task automatic do_reset();
    axis_resetn = 1'b0;
    clear_inputs();
    tick();
    tick();
    chk("rst_pifo_en",    32'(m_axis_ctl_pifo_out_en), 32'd0);
    chk("rst_rd_en",      32'(m_axis_ctl_buffer_rd_en), 32'd0);
    chk("rst_busy",       32'(m_axis_busy), 32'd0);
    chk("rst_resp_valid", 32'(m_axi_resp_valid), 32'd0);
    chk("rst_data",       m_axi_data, 32'd0);
    axis_resetn = 1'b1;
    tick();
  endtask

  task automatic cpu_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
    s_axi_addr      = a;
    s_axi_req_valid = 1'b1;
    tick();
    chk({nm, "_valid"}, 32'(m_axi_resp_valid), 32'd1);
    chk(nm, m_axi_data, exp);
    s_axi_req_valid = 1'b0;
    tick();
  endtask

  // Wait for the pop of queue q (expected on the first edge), then hand the
  // descriptor back so the DUT enters STREAM.
  task automatic pop_phase(input int q, input bit consume);
    logic [4:0] oh;
    int         guard;
    oh    = 5'(1) << q;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (m_axis_ctl_pifo_out_en == 5'd0 && guard < 8);
    chk("pop_onehot",  32'(m_axis_ctl_pifo_out_en), 32'(oh));
    chk("pop_latency", 32'(guard), 32'd1);
    chk("pop_busy",    32'(m_axis_busy), 32'd1);
    if (consume) s_axis_pifo_empty = s_axis_pifo_empty | oh;
    tick();
    chk("pop_one_cycle", 32'(m_axis_ctl_pifo_out_en), 32'd0);
    chk("wait_rd_en",    32'(m_axis_ctl_buffer_rd_en), 32'd0);
    s_axis_pifo_out_valid = 1'b1;
    tick();
    s_axis_pifo_out_valid = 1'b0;
  endtask

  task automatic serve(input int q, input int nbeats, input bit gaps, input bit consume);
    logic [4:0] oh;
    int         n;
    int         guard;
    oh = 5'(1) << q;
    pop_phase(q, consume);
    n     = 0;
    guard = 0;
    while (n < nbeats && guard < 500) begin
      s_axis_buf_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_axis_buf_tlast  = s_axis_buf_tvalid && (n == nbeats - 1);
      #1;
      chk("stream_rd_en", 32'(m_axis_ctl_buffer_rd_en), 32'(oh));
      tick();
      if (s_axis_buf_tvalid) n++;
      guard++;
    end
    s_axis_buf_tvalid = 1'b0;
    s_axis_buf_tlast  = 1'b0;
    chk("idle_after_pkt", 32'(m_axis_busy), 32'd0);
    chk("rd_en_after_pkt", 32'(m_axis_ctl_buffer_rd_en), 32'd0);
  endtask

  // Reference pick: first eligible queue at or after ptr, with optional
  // strict CPU priority.
  function automatic int model_pick(input logic [4:0] elig, input int p);
    int j;
`ifdef DEQ_STRICT_CPU_PRIO_EN
    if (elig[4]) return 4;
`endif
    for (int k = 0; k < 5; k++) begin
      j = (p + k) % 5;
      if (elig[j[2:0]]) return j;
    end
    return -1;
  endfunction

  function automatic int model_next_ptr(input int q, input int p);
`ifdef DEQ_STRICT_CPU_PRIO_EN
    if (q == 4) return p;
`endif
    return (q + 1) % 5;
  endfunction

  initial begin
    rd_vec_t    tbl [8];
    int         order [6];
    int         mptr;
    int         mcnt [5];
    int         q;
    logic [4:0] elig;

    tbl[0] = '{4'd1,  32'd1};
    tbl[1] = '{4'd3,  32'd1};
    tbl[2] = '{4'd5,  32'd0};
    tbl[3] = '{4'd9,  32'd0};
    tbl[4] = '{4'd0,  32'd0};
    tbl[5] = '{4'd4,  32'd0};
    tbl[6] = '{4'd2,  32'd0};
    tbl[7] = '{4'd15, 32'd0};

    clear_inputs();
    do_reset();

    // Queues 1 and 3 non-empty, 2-beat packets: q1 then q3
    s_axis_pifo_empty = 5'b10101;
    serve(1, 2, 1'b0, 1'b1);
    serve(3, 2, 1'b0, 1'b1);

    // Back-to-back CPU reads, responses on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      s_axi_addr      = tbl[i].addr;
      s_axi_req_valid = 1'b1;
      tick();
      chk("b2b_valid", 32'(m_axi_resp_valid), 32'd1);
      chk("b2b_data",  m_axi_data, tbl[i].exp);
    end
    s_axi_req_valid = 1'b0;
    tick();
    chk("resp_valid_drop", 32'(m_axi_resp_valid), 32'd0);

    // All queues eligible from rr_ptr = 0
    do_reset();
`ifdef DEQ_STRICT_CPU_PRIO_EN
    order = '{4, 4, 4, 4, 4, 4};
`else
    order = '{0, 1, 2, 3, 4, 0};
`endif
    s_axis_pifo_empty = 5'b00000;
    for (int i = 0; i < 6; i++) serve(order[i], 2, 1'b0, 1'b0);
    s_axis_pifo_empty = 5'b11111;
    tick();

    // q2 stalls for 3 cycles mid-packet via port_ready
    do_reset();
    s_axis_pifo_empty = 5'b11011;
    pop_phase(2, 1'b1);
    s_axis_buf_tvalid = 1'b1;
    #1;
    chk("stall_beat0", 32'(m_axis_ctl_buffer_rd_en), 32'b00100);
    tick();
    s_axis_port_ready = 5'b11011;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rd_en", 32'(m_axis_ctl_buffer_rd_en), 32'd0);
      chk("stall_busy",  32'(m_axis_busy), 32'd1);
      tick();
    end
    s_axis_port_ready = 5'b11111;
    #1;
    chk("stall_beat1", 32'(m_axis_ctl_buffer_rd_en), 32'b00100);
    tick();
    s_axis_buf_tlast = 1'b1;
    tick();
    s_axis_buf_tvalid = 1'b0;
    s_axis_buf_tlast  = 1'b0;
    chk("stall_done_idle", 32'(m_axis_busy), 32'd0);
    cpu_read(4'd2, 32'd1, "stall_pkt_cnt2");
    cpu_read(4'd5, 32'd0, "stall_abort_cnt");

    // q0 packet without tlast: watchdog abort after 64 beats
    do_reset();
    s_axis_pifo_empty = 5'b11110;
    pop_phase(0, 1'b1);
    s_axis_buf_tvalid = 1'b1;
    for (int b = 0; b < 64; b++) begin
      #1;
      chk("abort_rd_en", 32'(m_axis_ctl_buffer_rd_en), 32'b00001);
      tick();
    end
    chk("abort_idle",  32'(m_axis_busy), 32'd0);
    chk("abort_rd_en_drop", 32'(m_axis_ctl_buffer_rd_en), 32'd0);
    s_axis_buf_tvalid = 1'b0;
    cpu_read(4'd5, 32'd1, "abort_cnt");
    cpu_read(4'd0, 32'd0, "abort_pkt_cnt0");

    // Reset during STREAM: outputs drop asynchronously, counters cleared
    s_axis_pifo_empty = 5'b11101;
    pop_phase(1, 1'b1);
    s_axis_buf_tvalid = 1'b1;
    #1;
    chk("pre_rst_rd_en", 32'(m_axis_ctl_buffer_rd_en), 32'b00010);
    #1;
    axis_resetn = 1'b0;
    #1;
    chk("async_rst_rd_en",  32'(m_axis_ctl_buffer_rd_en), 32'd0);
    chk("async_rst_busy",   32'(m_axis_busy), 32'd0);
    chk("async_rst_pop",    32'(m_axis_ctl_pifo_out_en), 32'd0);
    s_axis_buf_tvalid = 1'b0;
    s_axis_pifo_empty = 5'b11111;
    tick();
    axis_resetn = 1'b1;
    tick();
    chk("post_rst_idle", 32'(m_axis_busy), 32'd0);
    cpu_read(4'd5, 32'd0, "post_rst_abort_cnt");
    cpu_read(4'd1, 32'd0, "post_rst_pkt_cnt1");

    // Randomized rounds against the reference model
    do_reset();
    mptr = 0;
    for (int i = 0; i < 5; i++) mcnt[i] = 0;
    for (int r = 0; r < 40; r++) begin
      s_axis_pifo_empty = 5'($urandom);
      s_axis_port_ready = 5'($urandom);
      elig = ~s_axis_pifo_empty & s_axis_port_ready;
      q = model_pick(elig, mptr);
      if (q < 0) begin
        for (int c = 0; c < 3; c++) begin
          tick();
          chk("rand_no_pop",  32'(m_axis_ctl_pifo_out_en), 32'd0);
          chk("rand_no_busy", 32'(m_axis_busy), 32'd0);
        end
      end else begin
        serve(q, $urandom_range(1, 6), 1'b1, 1'b0);
        mcnt[q]++;
        mptr = model_next_ptr(q, mptr);
      end
    end
    s_axis_pifo_empty = 5'b11111;
    tick();
    tick();
    for (int i = 0; i < 5; i++) cpu_read(4'(i), 32'(mcnt[i]), "rand_pkt_cnt");
    cpu_read(4'd5, 32'd0, "rand_abort_cnt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
